// File: rtl/ped_crossing_pkg.sv
// Shared encodings for the vehicle signal and pedestrian crossing FSM, plus
// the lamp bundle driven for each crossing state.
package ped_crossing_pkg;

  localparam logic [1:0] RED     = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] GREEN   = 2'b10;
  localparam logic [1:0] INVALID = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    WALK  = 2'b10,
    CLEAR = 2'b11
  } st_e;

  typedef struct packed {
    logic       walk;
    logic       dont_walk;
    logic [3:0] countdown;
    logic       req_pending;
  } lamp_t;

  localparam lamp_t LAMPS_IDLE = '{
    walk:        1'b0,
    dont_walk:   1'b1,
    countdown:   4'd0,
    req_pending: 1'b0
  };

  // Counter width that stays legal when the count range collapses to one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic lamp_t lamps_for(input st_e st, input logic [3:0] tmr,
                                      input logic flash);
    lamp_t l;
    l = LAMPS_IDLE;
    case (st)
      WAIT: l.req_pending = 1'b1;
      WALK: begin
        l.walk      = 1'b1;
        l.dont_walk = 1'b0;
        l.countdown = tmr;
      end
      CLEAR: begin
        l.dont_walk = flash;
        l.countdown = tmr;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ped_crossing_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer followed by a filter that only
// accepts a new level after DEBOUNCE consecutive identical samples.
module btn_debounce
  import ped_crossing_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = cnt_width(DEBOUNCE);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          settle;

  assign differ = (sync2 != level);
  assign settle = differ && (cnt == CW'(DEBOUNCE - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, which is what makes the sync chain a chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= settle && sync2;
      if (settle) begin
        level <= sync2;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ped_crossing.sv
// Pedestrian crossing controller slaved to a vehicle traffic controller:
// latches button requests and grants WALK only on a fresh red with enough time.
module ped_crossing
  import ped_crossing_pkg::*;
#(
  parameter logic [3:0] CLEAR_TIME = 4'd3,
  parameter int         FLASH_DIV  = 2,
  parameter int         DEBOUNCE   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] signal,
  input  logic [3:0] timer,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic [3:0] countdown,
  output logic       req_pending,
  output logic [7:0] served_cnt
);

  localparam int FW = cnt_width(FLASH_DIV);

  logic [1:0]    sig_q;
  logic [1:0]    sig_prev;
  logic [3:0]    timer_q;
  logic          red_entry;
  logic          btn_level;
  logic          btn_rise;
  logic          req_event;
  st_e           state;
  st_e           state_next;
  logic          served_inc;
  logic          flash;
  logic          flash_next;
  logic [FW-1:0] flash_cnt;
  logic [FW-1:0] flash_cnt_next;
  lamp_t         lamps_next;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (ped_btn),
    .level (btn_level),
    .rise  (btn_rise)
  );

  assign req_event = btn_rise && btn_level;

  // Reset to INVALID so a red already present when reset drops counts as fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q    <= INVALID;
      sig_prev <= INVALID;
      timer_q  <= '0;
    end else begin
      sig_prev <= sig_q;
      sig_q    <= signal;
      timer_q  <= timer;
    end
  end

  assign red_entry = (sig_q == RED) && (sig_prev != RED);

  // NOTE: every variable written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    served_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_event) state_next = WAIT;
      end
      WAIT: begin
        if (red_entry && (timer_q > CLEAR_TIME)) state_next = WALK;
      end
      WALK: begin
        if (sig_q == INVALID)           state_next = IDLE;
        else if (sig_q != RED)          state_next = CLEAR;
        else if (timer_q <= CLEAR_TIME) state_next = CLEAR;
      end
      CLEAR: begin
        if (sig_q == INVALID) begin
          state_next = IDLE;
        end else if (sig_q != RED) begin
          state_next = IDLE;
          served_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Flash phase restarts lit on every CLEAR entry, then toggles each FLASH_DIV cycles.
  always_comb begin
    flash_next     = flash;
    flash_cnt_next = flash_cnt;
    if (state_next == CLEAR) begin
      if (state != CLEAR) begin
        flash_next     = 1'b1;
        flash_cnt_next = '0;
      end else if (flash_cnt == FW'(FLASH_DIV - 1)) begin
        flash_next     = ~flash;
        flash_cnt_next = '0;
      end else begin
        flash_cnt_next = flash_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    lamps_next = lamps_for(state_next, timer_q, flash_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      flash       <= 1'b0;
      flash_cnt   <= '0;
      walk        <= LAMPS_IDLE.walk;
      dont_walk   <= LAMPS_IDLE.dont_walk;
      countdown   <= LAMPS_IDLE.countdown;
      req_pending <= LAMPS_IDLE.req_pending;
      served_cnt  <= '0;
    end else begin
      state       <= state_next;
      flash       <= flash_next;
      flash_cnt   <= flash_cnt_next;
      walk        <= lamps_next.walk;
      dont_walk   <= lamps_next.dont_walk;
      countdown   <= lamps_next.countdown;
      req_pending <= lamps_next.req_pending;
      if (served_inc) served_cnt <= served_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ped_crossing.sv
// Scoreboarded bench for ped_crossing: a history-window reference model predicts
// the lamps after every clock edge; a monitor compares them against the outputs.
module tb_ped_crossing;
  import ped_crossing_pkg::*;

  localparam logic [3:0] CT = 4'd3;
  localparam int         FD = 2;
  localparam int         DB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] signal = GREEN;
  logic [3:0] timer = 4'd0;
  logic       ped_btn = 1'b0;
  logic       walk;
  logic       dont_walk;
  logic [3:0] countdown;
  logic       req_pending;
  logic [7:0] served_cnt;

  always #5 clk = ~clk;

  ped_crossing #(.CLEAR_TIME(CT), .FLASH_DIV(FD), .DEBOUNCE(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .signal      (signal),
    .timer       (timer),
    .ped_btn     (ped_btn),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .countdown   (countdown),
    .req_pending (req_pending),
    .served_cnt  (served_cnt)
  );

  typedef struct {
    logic       walk;
    logic       dont_walk;
    logic [3:0] countdown;
    logic       req_pending;
    logic [7:0] served;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_WAIT, P_WALK, P_CLEAR} phase_e;

  phase_e     m_phase;
  logic [1:0] m_sig_hist[$];   // [0] = older, [1] = newer registered signal
  logic [3:0] m_tim;
  bit         m_btn_line[$];   // raw button samples still in the synchronizer
  bit         m_win[$];        // most recent samples seen by the filter
  bit         m_level;
  bit         m_rise;
  int         m_served;
  int         m_clear_age;

  task automatic model_reset();
    m_phase     = P_IDLE;
    m_sig_hist  = {INVALID, INVALID};
    m_tim       = 4'd0;
    m_btn_line  = {1'b0, 1'b0};
    m_win       = {};
    m_level     = 1'b0;
    m_rise      = 1'b0;
    m_served    = 0;
    m_clear_age = 0;
  endtask

  task automatic model_step(input bit r, input logic [1:0] s, input logic [3:0] t,
                            input bit b, output exp_t e);
    logic [1:0] rs;
    logic [1:0] rp;
    bit         red_entry;
    phase_e     nxt;
    bit         s_old;
    bit         all_flip;
    if (r) begin
      model_reset();
      e = '{1'b0, 1'b1, 4'd0, 1'b0, 8'd0};
      return;
    end
    rs        = m_sig_hist[1];
    rp        = m_sig_hist[0];
    red_entry = (rs == RED) && (rp != RED);
    nxt       = m_phase;
    case (m_phase)
      P_IDLE:  if (m_rise) nxt = P_WAIT;
      P_WAIT:  if (red_entry && m_tim > CT) nxt = P_WALK;
      P_WALK: begin
        if (rs == INVALID)  nxt = P_IDLE;
        else if (rs != RED) nxt = P_CLEAR;
        else if (m_tim <= CT) nxt = P_CLEAR;
      end
      P_CLEAR: begin
        if (rs == INVALID) nxt = P_IDLE;
        else if (rs != RED) begin
          nxt      = P_IDLE;
          m_served = m_served + 1;
        end
      end
      default: nxt = P_IDLE;
    endcase
    if (nxt == P_CLEAR) m_clear_age = (m_phase == P_CLEAR) ? m_clear_age + 1 : 0;
    m_phase = nxt;

    e.walk        = (nxt == P_WALK);
    e.dont_walk   = (nxt == P_CLEAR) ? (((m_clear_age / FD) % 2) == 0) : (nxt != P_WALK);
    e.countdown   = (nxt == P_WALK || nxt == P_CLEAR) ? m_tim : 4'd0;
    e.req_pending = (nxt == P_WAIT);
    e.served      = 8'(m_served % 256);

    void'(m_sig_hist.pop_front());
    m_sig_hist.push_back(s);
    m_tim = t;

    s_old = m_btn_line.pop_front();
    m_btn_line.push_back(b);
    m_win.push_back(s_old);
    if (m_win.size() > DB) void'(m_win.pop_front());
    m_rise = 1'b0;
    if (m_win.size() == DB) begin
      all_flip = 1'b1;
      foreach (m_win[i]) if (m_win[i] == m_level) all_flip = 1'b0;
      if (all_flip) begin
        m_level = !m_level;
        m_rise  = m_level;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit r, input logic [1:0] s, input logic [3:0] t, input bit b);
    exp_t e;
    @(negedge clk);
    rst     = r;
    signal  = s;
    timer   = t;
    ped_btn = b;
    model_step(r, s, t, b, e);
    exp_q.push_back(e);
  endtask

  task automatic press_on_green();
    repeat (6) cyc(1'b0, GREEN, 4'd5, 1'b1);
    repeat (2) cyc(1'b0, GREEN, 4'd4, 1'b0);
  endtask

  task automatic crossing();
    press_on_green();
    repeat (2) cyc(1'b0, RED, 4'd6, 1'b0);
    repeat (3) cyc(1'b0, RED, 4'd2, 1'b0);
    repeat (2) cyc(1'b0, GREEN, 4'd9, 1'b0);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("walk",        8'(walk),        8'(e.walk));
        check("dont_walk",   8'(dont_walk),   8'(e.dont_walk));
        check("countdown",   8'(countdown),   8'(e.countdown));
        check("req_pending", 8'(req_pending), 8'(e.req_pending));
        check("served_cnt",  served_cnt,      e.served);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  bit glitch[]  = '{1, 1, 0, 0, 0, 0, 0, 0};
  bit bounce[]  = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    int         sel;
    int         len;
    int         t0;
    int         press;
    logic [1:0] s;

    model_reset();
    repeat (3) cyc(1'b1, GREEN, 4'd0, 1'b0);

    // Held press during green, served by a red with a long timer.
    repeat (4) cyc(1'b0, GREEN, 4'd9, 1'b0);
    repeat (5) cyc(1'b0, GREEN, 4'd8, 1'b1);
    repeat (4) cyc(1'b0, GREEN, 4'd7, 1'b0);
    repeat (3) cyc(1'b0, YELLOW, 4'd2, 1'b0);
    for (int t = 10; t >= 0; t--) repeat (2) cyc(1'b0, RED, 4'(t), 1'b0);
    repeat (4) cyc(1'b0, GREEN, 4'd9, 1'b0);

    // Short glitch in IDLE, then a bouncy press.
    foreach (glitch[i]) cyc(1'b0, GREEN, 4'd6, glitch[i]);
    foreach (bounce[i]) cyc(1'b0, GREEN, 4'd6, bounce[i]);

    // Red with too little time keeps the request waiting; next red serves it.
    repeat (3) cyc(1'b0, RED, 4'd3, 1'b0);
    repeat (3) cyc(1'b0, GREEN, 4'd5, 1'b0);
    repeat (3) cyc(1'b0, RED, 4'd10, 1'b0);
    // Invalid signal during WALK drops to IDLE without counting a crossing.
    repeat (2) cyc(1'b0, INVALID, 4'd9, 1'b0);
    repeat (3) cyc(1'b0, GREEN, 4'd5, 1'b0);

    // Reset mid-WALK with several crossings already counted.
    while ((m_served % 256) != 7) crossing();
    press_on_green();
    repeat (3) cyc(1'b0, RED, 4'd10, 1'b0);
    cyc(1'b1, RED, 4'd9, 1'b0);
    repeat (3) cyc(1'b0, RED, 4'd8, 1'b0);
    repeat (3) cyc(1'b0, GREEN, 4'd8, 1'b0);

    // Counter wrap from 255 to 0.
    while ((m_served % 256) != 255) crossing();
    crossing();
    crossing();

    // Randomized traffic phases with noisy button activity.
    for (int p = 0; p < 220; p++) begin
      sel   = $urandom_range(0, 9);
      s     = (sel < 4) ? GREEN : (sel < 6) ? YELLOW : (sel < 9) ? RED : INVALID;
      len   = $urandom_range(1, 12);
      t0    = $urandom_range(0, 15);
      press = $urandom_range(0, 10);
      for (int c = 0; c < len; c++)
        cyc(1'b0, s, 4'((t0 > c) ? (t0 - c) : 0), ($urandom_range(0, 9) < press));
      if ($urandom_range(0, 60) == 0) cyc(1'b1, s, 4'd0, 1'b0);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ped_crossing.md
PED_CROSSING -- requirements
Module: ped_crossing

Interface
REQ-001 Parameter CLEAR_TIME, default 4'd3, timer value at or below which WALK ends and flashing clearance begins.
REQ-002 Parameter FLASH_DIV, default 2, clk cycles per flash half-period during CLEAR.
REQ-003 Parameter DEBOUNCE, default 3, consecutive identical clk samples of ped_btn required before its debounced level changes.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port signal  input  2  vehicle light state from the traffic controller: 00 red, 01 yellow, 10 green, 11 invalid.
REQ-007 Port timer  input  4  remaining phase count from the traffic controller.
REQ-008 Port ped_btn  input  1  raw, asynchronous, bouncing pedestrian push-button, active-high.
REQ-009 Port walk  output  1  WALK lamp.
REQ-010 Port dont_walk  output  1  DON'T WALK lamp, solid or flashing.
REQ-011 Port countdown  output  4  pedestrian countdown display value.
REQ-012 Port req_pending  output  1  request-acknowledged lamp.
REQ-013 Port served_cnt  output  8  number of completed crossings.

Function
REQ-014 ped_btn SHALL pass through a 2-flop synchronizer and then a DEBOUNCE-sample stability filter; a request event is a 0->1 transition of the debounced level.
REQ-015 signal and timer SHALL be registered once; red_entry = (registered signal == 00) and (previous registered signal != 00).
REQ-016 The FSM SHALL have states IDLE, WAIT, WALK, CLEAR.
REQ-017 IDLE: request event -> WAIT and req_pending=1.
REQ-018 WAIT: on red_entry with timer > CLEAR_TIME -> WALK and req_pending=0; on red_entry with timer <= CLEAR_TIME -> stay in WAIT with req_pending=1.
REQ-019 WALK: when registered timer <= CLEAR_TIME -> CLEAR; when registered signal != 00 -> CLEAR.
REQ-020 CLEAR: when registered signal != 00 -> IDLE and served_cnt += 1, wrapping 255->0.
REQ-021 A request event in WALK or CLEAR SHALL be ignored; a request event in WAIT has no additional effect.
REQ-022 A request event in the same cycle as red_entry while in IDLE SHALL set req_pending and go to WAIT; it is served at the next red_entry, never mid-red.
REQ-023 Signal value 11 SHALL be treated as non-red; in WALK or CLEAR it forces IDLE without incrementing served_cnt.
REQ-024 Outputs SHALL be registered and depend on state only:
- IDLE and WAIT: walk=0, dont_walk=1, countdown=0.
- WALK: walk=1, dont_walk=0, countdown = registered timer.
- CLEAR: walk=0, dont_walk = flash phase, countdown = registered timer.
REQ-025 On CLEAR entry, flash phase SHALL be 1; it toggles every FLASH_DIV cycles while in CLEAR.
REQ-026 Latency: signal/timer input change -> output change SHALL be 2 clk cycles (input register plus output register).

Reset
REQ-027 rst=1 at a rising clk edge SHALL set, regardless of state including mid-WALK:
- state=IDLE, walk=0, dont_walk=1, countdown=0, req_pending=0, served_cnt=0.
- Synchronizer, debounce counter and filter level all cleared to 0.
- Registered signal cleared to 11, so a red signal present at release produces a red_entry.

Structure
REQ-028 A shared package SHALL hold the signal encodings (RED=2'b00, YELLOW=2'b01, GREEN=2'b10) and the state enumeration; the traffic controller and this block use the same encodings.
REQ-029 The synchronizer and debounce filter SHALL be a separate sub-module, btn_debounce (DEBOUNCE parameter, outputs debounced level and rise pulse).

Verification
REQ-030 Press held 5 cycles during green, then red entry with timer=10 -> req_pending=1 until red entry; walk=1, countdown tracks 10..4; CLEAR while timer 3..0.
REQ-031 In CLEAR with FLASH_DIV=2 -> dont_walk reads 1,1,0,0,1,1...; signal goes green -> IDLE, served_cnt 0->1, dont_walk=1 solid.
REQ-032 Bounce pattern 1,0,1,0 then stable 1 for 3 samples -> exactly one request event; a 2-cycle glitch -> none.
REQ-033 Request pending and red entry with timer=3 -> stays WAIT, walk=0; next red entry with timer=10 -> WALK.
REQ-034 rst asserted mid-WALK with served_cnt=7 -> next cycle walk=0, dont_walk=1, countdown=0, served_cnt=0, req_pending=0.
REQ-035 served_cnt=255 and a crossing completes -> served_cnt=0; signal=11 during WALK -> IDLE with served_cnt unchanged.
